// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state numbering (common with the TX FSM),
// default frame geometry and parity polarity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int unsigned BAUD_DIV_DEF  = 16;
  localparam int unsigned DATA_BITS_DEF = 8;

  // 0 selects even parity: the XOR of data plus parity bit must be 0.
  localparam logic PARITY_ODD = 1'b0;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line, with a delayed copy
// used to flag a high-to-low transition (start edge).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic start_c
);

  logic rx_meta;
  logic rx_prev;

  // Line idles high, so all stages reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_c = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: start detection, mid-bit sampling, LSB-first deserialise,
// stop check. Define UART_RX_PARITY_EN to add an even-parity bit and check.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [IW-1:0]        bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 rx_s;
  logic                 start_c;
  logic                 done_c;
`ifdef UART_RX_PARITY_EN
  logic                 perr, perr_next;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .start_c (start_c)
  );

  // Next-state and datapath; every sample point clears the bit-time counter.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CW'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift;
    done_c       = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next    = perr;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start_c) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[DATA_BITS-1:1]};
          bit_idx_next = bit_idx + IW'(1);
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          perr_next  = rx_s ^ (^shift) ^ PARITY_ODD;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          done_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; results publish as DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr       <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      rx_done <= done_c;
      busy    <= (state_next != IDLE);
`ifdef UART_RX_PARITY_EN
      perr    <= perr_next;
`endif
      if (done_c) begin
        rx_data   <= shift;
        frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= perr;
`else
        parity_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed frames plus random traffic
// checked by a frame-level scoreboard (data, flags, strobe timing).
module tb_uart_rx_fsm;

  localparam int unsigned BAUD = 16;
  localparam int unsigned DW   = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  // Cycles from driving the start bit to seeing rx_done just after an edge.
  localparam int unsigned LAT = 1 + 2 + BAUD / 2 + (DW + 1 + P) * BAUD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx_fsm #(.BAUD_DIV(BAUD), .DATA_BITS(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned t;
  } exp_t;

  exp_t        expq[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic [7:0]  last_data = 8'h00;
  logic        prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
    exp_t e;
    e.d  = d;
    e.pe = (P != 0) ? (pbit ^ (^d)) : 1'b0;
    e.fe = ~sbit;
    e.t  = cyc + LAT;
    expq.push_back(e);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < int'(DW); i++) begin
      rx = d[i];
      repeat (BAUD) @(negedge clk);
    end
    if (P != 0) begin
      rx = pbit;
      repeat (BAUD) @(negedge clk);
    end
    rx = sbit;
    repeat (BAUD) @(negedge clk);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding frame.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_done) begin
        chk("strobe_width", 32'(rx_done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
      end
      if (rx_done) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 32'(expq.size()), 32'd1);
        end else begin
          e = expq.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.d));
          chk("parity_err", 32'(parity_err), 32'(e.pe));
          chk("frame_err", 32'(frame_err), 32'(e.fe));
          chk("done_cycle", cyc, e.t);
          last_data = e.d;
        end
      end
      prev_done = rx_done;
    end
  end

  initial begin
    logic [7:0] d;
    logic       pb;
    logic       sb;
    bit         ok;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(5);

    // Good frame, then bad parity, then bad stop with the line held low.
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    idle(20);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(20);

    // Short glitch must not start a frame.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < int'(BAUD / 2 + 3); i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("glitch_busy_clear", 32'(ok), 32'd1);
    chk("glitch_rx_data", 32'(rx_data), 32'(last_data));
    idle(2 * BAUD);

    // Reset pulse in the data phase of a 0xFF frame discards it.
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (BAUD + 5) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    chk("abort_rx_done", 32'(rx_done), 32'd0);
    chk("abort_parity_err", 32'(parity_err), 32'd0);
    chk("abort_frame_err", 32'(frame_err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    last_data = 8'h00;
    idle(4 * BAUD);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(5);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(5);

    // Random traffic: occasional parity/stop errors and random gaps.
    repeat (40) begin
      d  = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(d, pb, sb);
      if (!sb || ($urandom_range(0, 1) == 0))
        idle(32'($urandom_range(3, 30)));
    end
    idle(5);

    for (int i = 0; i < int'(2 * LAT) && expq.size() != 0; i++) @(negedge clk);
    chk("frames_outstanding", 32'(expq.size()), 32'd0);
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
